// File: rtl/four_bit_adder_pkg.sv
// Shared widths and types for the small carry-preserving adder.
package four_bit_adder_pkg;
    localparam int OPW  = 4;
    localparam int SUMW = OPW + 1;

    typedef logic [OPW-1:0]  operand_t;
    typedef logic [SUMW-1:0] sum_t;
endpackage

// File: rtl/four_bit_adder_core_full_adder.sv
// One-bit full adder; the ripple chain in four_bit_adder_core is built from these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/four_bit_adder_core.sv
// Unsigned 4-bit ripple-carry adder with a combinational 5-bit sum and a
// registered copy qualified by out_valid.
module four_bit_adder_core
    import four_bit_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH:0]   out,
    output logic [WIDTH:0]   out_q,
    output logic             out_valid
);
    operand_t        sum_bits;
    logic [OPW:0]    carry;
    sum_t            sum_d;
    sum_t            sum_q;
    logic            valid_d;
    logic            valid_q;

    // Stage i consumes carry[i] and produces bit i plus carry[i+1].
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < OPW; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    assign out = {carry[OPW], sum_bits};

    always_comb begin
        sum_d   = sum_q;
        valid_d = 1'b0;
        if (in_valid) begin
            sum_d   = out;
            valid_d = 1'b1;
        end
    end

    // Reset takes priority over a capture presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign out_q     = sum_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_four_bit_adder_core.sv
// Directed-vector bench for four_bit_adder_core: combinational sum, registered
// capture, reset priority, random pairs and a full operand sweep.
module tb_four_bit_adder_core;
    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [4:0] out;
    logic [4:0] out_q;
    logic       out_valid;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp_sum;
    } vec_t;

    vec_t vecs [7];

    four_bit_adder_core #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] actual, input logic [4:0] required);
        n_vec++;
        if (actual !== required) begin
            n_err++;
            $display("FAIL %s: got %0d (%b), expected %0d (%b)", name, actual, actual, required, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_v;
        logic [3:0] ra;
        logic [3:0] rb;

        n_vec = 0;
        n_err = 0;

        vecs[0] = '{4'd0,  4'd0,  5'd0};
        vecs[1] = '{4'd15, 4'd15, 5'd30};
        vecs[2] = '{4'd9,  4'd7,  5'd16};
        vecs[3] = '{4'd8,  4'd7,  5'd15};
        vecs[4] = '{4'd3,  4'd4,  5'd7};
        vecs[5] = '{4'd10, 4'd5,  5'd15};
        vecs[6] = '{4'd1,  4'd1,  5'd2};

        rst = 1'b1;
        in_valid = 1'b0;
        a = 4'd5;
        b = 4'd6;
        #1;
        check("out_during_reset", out, 5'd11);
        tick();
        tick();
        check("reset_out_q", out_q, 5'd0);
        check("reset_out_valid", {4'b0, out_valid}, 5'd0);

        rst = 1'b0;
        // Back-to-back captures: every table entry lands on consecutive edges.
        for (int i = 0; i < 7; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            in_valid = 1'b1;
            #1;
            check($sformatf("out_vec%0d", i), out, vecs[i].exp_sum);
            tick();
            check($sformatf("out_q_vec%0d", i), out_q, vecs[i].exp_sum);
            check($sformatf("out_valid_vec%0d", i), {4'b0, out_valid}, 5'd1);
        end

        in_valid = 1'b0;
        a = 4'd14;
        b = 4'd3;
        tick();
        check("idle_out_valid", {4'b0, out_valid}, 5'd0);
        check("idle_out_q_hold", out_q, 5'd2);
        check("idle_out", out, 5'd17);
        tick();
        check("idle2_out_q_hold", out_q, 5'd2);

        rst = 1'b1;
        in_valid = 1'b1;
        a = 4'd12;
        b = 4'd6;
        #1;
        check("rst_cap_out_before", out, 5'd18);
        tick();
        check("rst_cap_out_q", out_q, 5'd0);
        check("rst_cap_out_valid", {4'b0, out_valid}, 5'd0);
        check("rst_cap_out_after", out, 5'd18);
        rst = 1'b0;
        tick();
        check("post_rst_out_q", out_q, 5'd18);
        check("post_rst_out_valid", {4'b0, out_valid}, 5'd1);

        for (int i = 0; i < 10; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            exp_v = {1'b0, ra} + {1'b0, rb};
            a = ra;
            b = rb;
            in_valid = 1'b1;
            #1;
            check($sformatf("rand_out_%0d+%0d", ra, rb), out, exp_v);
            tick();
            check($sformatf("rand_out_q_%0d+%0d", ra, rb), out_q, exp_v);
            check($sformatf("rand_valid_%0d", i), {4'b0, out_valid}, 5'd1);
        end

        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a = 4'(i);
                b = 4'(j);
                #1;
                check($sformatf("sweep_%0d+%0d", i, j), out, 5'(i + j));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/four_bit_adder_core.md
# four_bit_adder_core

Unsigned 4-bit ripple-carry adder with a 5-bit result that includes the carry-out. The result is available combinationally, so it can be compared in the same cycle the operands are applied. A registered copy with a valid flag is also provided for pipelined consumers. It is a leaf arithmetic block used wherever a small carry-out-preserving add is needed.

## Interface
Parameters:
- WIDTH, default 4: operand width. Fixed at 4 for this block; any other value is unsupported.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- rst  input  1  Reset, synchronous, active-high.
- a  input  4  Operand A, unsigned.
- b  input  4  Operand B, unsigned.
- in_valid  input  1  Qualifies a/b for capture into the output register.
- out  output  5  Combinational sum, a + b. out[4] is the carry-out.
- out_q  output  5  Registered sum of the last captured operands.
- out_valid  output  1  out_q holds a result captured on the previous edge.

## Operation
- out = zero-extended a + zero-extended b, exact, 5 bits.
  - Range is 0..30; overflow cannot occur.
  - out[4] = 1 exactly when a + b ≥ 16.
- out is built as a 4-stage ripple chain of full adders.
  - Stage 0 carry-in is tied to 0.
  - Stage i produces out[i]; the stage 3 carry-out drives out[4].
- out is purely combinational.
  - It is independent of clk, rst and in_valid.
  - It is valid during reset.
- Registered path, evaluated on every rising edge:
  - rst = 1: out_q ← 0, out_valid ← 0.
  - else if in_valid = 1: out_q ← a + b, out_valid ← 1.
  - else: out_q holds its value; out_valid ← 0.
- No backpressure exists. A new operand pair may be accepted every cycle.
- X/Z on a or b propagates to out. The block does not sanitize its inputs.

## Timing
- out has 0-cycle latency: it settles within the same delta/cycle as an a/b change.
- out_q and out_valid have 1-cycle latency: operands sampled with in_valid at edge N appear after edge N.
- Reset values:
  - out_q = 5'b00000, out_valid = 0.
  - out has no reset value; it always follows a and b.
- Reset during operation: if rst is high at an edge, it wins over in_valid. The pair presented at that edge is discarded, and out_valid is 0 after the edge.
- Back-to-back valid cycles: out_valid stays high and out_q updates every cycle.
- Critical path: a[0]/b[0] through 4 carry stages to out[4]. This must close at the system clock.

## Structure
- Shared package four_bit_adder_pkg holds:
  - localparam OPW = 4.
  - localparam SUMW = OPW + 1.
  - typedef logic [OPW-1:0] operand_t.
  - typedef logic [SUMW-1:0] sum_t.
- Sub-module full_adder (inputs a, b, cin; outputs s, cout) is instantiated 4 times in a generate loop.
- The top level contains the ripple chain, the out_q/out_valid register, and the reset logic.

## Test plan
- a=0, b=0 → out=5'b00000. After one edge with in_valid=1: out_q=0, out_valid=1.
- a=15, b=15 → out=5'b11110 (30), carry set. Registered result is out_q=30 on the next edge.
- a=9, b=7 → out=5'b10000 (16), carry boundary. Also check a=8, b=7 → out=5'b01111 (15), carry clear.
- in_valid pulses over three consecutive edges with (3,4), (10,5), (1,1) → out_q sequence is 7, 15, 2, with out_valid high for each. After in_valid drops, out_valid falls and out_q holds 2.
- rst=1 asserted together with in_valid=1, a=12, b=6:
  - After the edge: out_q=0, out_valid=0.
  - out=18 throughout.
  - Deassert rst → normal capture resumes on the next edge.
- Randomized: 7+ pairs from $urandom, one per clock. For each, check out == a+b in the same cycle and out_q == a+b one edge later. Exhaustive 256-pair sweep of out is also required.
